// File: rtl/wrr_input_arbiter.sv
// wrr_input_arbiter
// Merges NUM_QUEUES rx-queue packet streams into one datapath stream.
// Whole packets are served in weighted round-robin order. Each queue may send
// up to weight[i] consecutive packets per turn; a weight of 0 counts as 1.
// Each queue has a first-word-fall-through FIFO built on an inferred RAM
// with a registered read port.
// Optional feature macro: IN_ARB_PKT_CNT_EN enables the per-queue packet
// counters on pkt_cnt. Without it, pkt_cnt is tied to zero.

module wrr_input_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 8,
    parameter int FIFO_DEPTH_BITS = 5,
    parameter int WEIGHT_WIDTH    = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]  pkt_cnt
);

    localparam int QW    = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int FW    = DATA_WIDTH + CTRL_WIDTH;
    // One word of headroom: upstream registers its write strobe, so it may
    // still issue one word after in_rdy drops.
    localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);
    localparam logic [QW-1:0]            LAST_Q   = QW'(NUM_QUEUES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } state_t;

    // Per-queue FIFO head words and status
    logic [FW-1:0]         head [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] fifo_empty;
    logic [NUM_QUEUES-1:0] pop;

    // ------------------------------------------------------------------
    // Per-queue first-word-fall-through FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_fifo
            logic [FW-1:0]              mem [DEPTH];
            logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg;
            logic [FIFO_DEPTH_BITS-1:0] rd_ptr_reg;
            logic [FIFO_DEPTH_BITS-1:0] rd_ptr_next;
            logic [FIFO_DEPTH_BITS:0]   count_reg;
            logic [FW-1:0]              head_reg;
            logic [FW-1:0]              wr_word;

            assign wr_word     = {in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH],
                                  in_data[gi*DATA_WIDTH +: DATA_WIDTH]};
            assign rd_ptr_next = rd_ptr_reg + FIFO_DEPTH_BITS'(pop[gi]);

            // RAM write port
            always_ff @(posedge clk) begin
                if (in_wr[gi]) begin
                    mem[wr_ptr_reg] <= wr_word;
                end
            end

            // Registered read of the next head; a word written into the head
            // slot in the same cycle is forwarded around the RAM.
            always_ff @(posedge clk) begin
                if (in_wr[gi] && (wr_ptr_reg == rd_ptr_next)) begin
                    head_reg <= wr_word;
                end else begin
                    head_reg <= mem[rd_ptr_next];
                end
            end

            // Pointer and occupancy bookkeeping; simultaneous write and pop
            // leave the occupancy unchanged.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_reg + FIFO_DEPTH_BITS'(in_wr[gi]);
                    rd_ptr_reg <= rd_ptr_next;
                    count_reg  <= count_reg
                                  + (FIFO_DEPTH_BITS + 1)'(in_wr[gi])
                                  - (FIFO_DEPTH_BITS + 1)'(pop[gi]);
                end
            end

            assign fifo_empty[gi] = (count_reg == '0);
            assign in_rdy[gi]     = (count_reg < NF_LEVEL);
            assign head[gi]       = head_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    state_t                  state_reg, state_next;
    logic [QW-1:0]           cur_queue_reg, cur_queue_next;
    logic [WEIGHT_WIDTH-1:0] served_reg, served_next;
    logic                    prev_ctrl_zero_reg, prev_ctrl_zero_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic [CTRL_WIDTH-1:0]   out_ctrl_reg, out_ctrl_next;
    logic                    out_wr_reg, out_wr_next;

    logic [FW-1:0]           cur_head;
    logic [CTRL_WIDTH-1:0]   cur_ctrl;
    logic                    cur_empty;
    logic [WEIGHT_WIDTH-1:0] cur_weight;
    logic [WEIGHT_WIDTH:0]   eff_weight;
    logic [WEIGHT_WIDTH:0]   served_inc;
    logic [QW-1:0]           next_queue;
    logic                    xfer_pop;
    logic                    cur_eop;

    assign cur_head   = head[cur_queue_reg];
    assign cur_ctrl   = cur_head[FW-1 -: CTRL_WIDTH];
    assign cur_empty  = fifo_empty[cur_queue_reg];
    assign cur_weight = weights[cur_queue_reg*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign eff_weight = (cur_weight == '0) ? (WEIGHT_WIDTH + 1)'(1) : {1'b0, cur_weight};
    assign served_inc = {1'b0, served_reg} + (WEIGHT_WIDTH + 1)'(1);
    assign next_queue = (cur_queue_reg == LAST_Q) ? '0 : cur_queue_reg + QW'(1);
    assign xfer_pop   = (state_reg == ST_XFER) && out_rdy && !cur_empty;
    // The first word of a packet can never be eop because IDLE clears the flag.
    assign cur_eop    = (cur_ctrl != '0) && prev_ctrl_zero_reg;

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            cur_queue_reg      <= '0;
            served_reg         <= '0;
            prev_ctrl_zero_reg <= 1'b0;
            out_data_reg       <= '0;
            out_ctrl_reg       <= '0;
            out_wr_reg         <= 1'b0;
        end else begin
            state_reg          <= state_next;
            cur_queue_reg      <= cur_queue_next;
            served_reg         <= served_next;
            prev_ctrl_zero_reg <= prev_ctrl_zero_next;
            out_data_reg       <= out_data_next;
            out_ctrl_reg       <= out_ctrl_next;
            out_wr_reg         <= out_wr_next;
        end
    end

    // Next-state logic: IDLE picks a queue, XFER moves one whole packet
    always_comb begin
        state_next          = state_reg;
        cur_queue_next      = cur_queue_reg;
        served_next         = served_reg;
        prev_ctrl_zero_next = prev_ctrl_zero_reg;
        out_data_next       = out_data_reg;
        out_ctrl_next       = out_ctrl_reg;
        out_wr_next         = 1'b0;
        pop                 = '0;

        case (state_reg)
            ST_IDLE: begin
                if (!cur_empty) begin
                    state_next          = ST_XFER;
                    prev_ctrl_zero_next = 1'b0;
                end else begin
                    cur_queue_next = next_queue;
                    served_next    = '0;
                end
            end
            ST_XFER: begin
                // An empty FIFO mid-packet simply stalls here.
                if (xfer_pop) begin
                    pop[cur_queue_reg]  = 1'b1;
                    out_data_next       = cur_head[DATA_WIDTH-1:0];
                    out_ctrl_next       = cur_ctrl;
                    out_wr_next         = 1'b1;
                    prev_ctrl_zero_next = (cur_ctrl == '0);
                    if (cur_eop) begin
                        state_next = ST_IDLE;
                        if (served_inc < eff_weight) begin
                            served_next = served_inc[WEIGHT_WIDTH-1:0];
                        end else begin
                            served_next    = '0;
                            cur_queue_next = next_queue;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_data = out_data_reg;
    assign out_ctrl = out_ctrl_reg;
    assign out_wr   = out_wr_reg;

    // ------------------------------------------------------------------
    // Per-queue forwarded-packet counters
    // ------------------------------------------------------------------
`ifdef IN_ARB_PKT_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;

            // Count each eop popped from this queue; wraps on overflow
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (xfer_pop && cur_eop && (cur_queue_reg == QW'(gi))) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end

            assign pkt_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
        end
    endgenerate
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_wrr_input_arbiter.sv
// Testbench for wrr_input_arbiter: directed packets loaded into the queue
// FIFOs, expected output words queued in hand-computed order, and a monitor
// that compares every out_wr word against the head of the scoreboard.

module tb_wrr_input_arbiter;

    localparam int DW  = 64;
    localparam int CW  = 8;
    localparam int NQ  = 8;
    localparam int WW  = 4;
    localparam int CNW = 16;

`ifdef IN_ARB_PKT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NQ*DW-1:0]  in_data = '0;
    logic [NQ*CW-1:0]  in_ctrl = '0;
    logic [NQ-1:0]     in_wr = '0;
    logic [NQ-1:0]     in_rdy;
    logic [NQ*WW-1:0]  weights = '0;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy = 1'b0;
    logic [NQ*CNW-1:0] pkt_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [CW+DW-1:0] sb [$];

    wrr_input_arbiter #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ),
        .FIFO_DEPTH_BITS(5), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CNW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .weights(weights),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Word encoding: queue, packet number and word index make every word unique
    function automatic logic [CW+DW-1:0] word_of(int q, int p, int i, int n, logic [CW-1:0] fc);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        d = (64'(q) << 48) | (64'(p) << 32) | 64'(i) | 64'hA000_0000;
        c = (i == 0) ? fc : ((i == n - 1) ? 8'h01 : 8'h00);
        return {c, d};
    endfunction

    function automatic logic [CNW-1:0] exp_cnt(int n);
        return CNT_EN ? CNW'(n) : '0;
    endfunction

    // Monitor: every output word must match the scoreboard head
    always @(negedge clk) begin
        if (out_wr === 1'b1) begin
            if (sb.size() == 0) begin
                check(1'b0, "unexpected_word", {out_ctrl, out_data}, '0);
            end else begin
                logic [CW+DW-1:0] e;
                e = sb.pop_front();
                $display("out word ctrl=%02h data=%016h expected ctrl=%02h data=%016h",
                         out_ctrl, out_data, e[CW+DW-1:DW], e[DW-1:0]);
                check({out_ctrl, out_data} === e, "out_word", {out_ctrl, out_data}, e);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge
    task automatic write_word(input int q, input logic [CW+DW-1:0] w);
        in_data[q*DW +: DW] = w[DW-1:0];
        in_ctrl[q*CW +: CW] = w[CW+DW-1:DW];
        in_wr[q] = 1'b1;
        @(posedge clk); #1;
        in_wr = '0;
    endtask

    task automatic load_pkt(input int q, input int p, input int n, input logic [CW-1:0] fc);
        for (int i = 0; i < n; i++) write_word(q, word_of(q, p, i, n, fc));
    endtask

    task automatic expect_pkt(input int q, input int p, input int n, input logic [CW-1:0] fc);
        for (int i = 0; i < n; i++) sb.push_back(word_of(q, p, i, n, fc));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; out_rdy = 1'b0; in_wr = '0;
        idle_cycles(3);
        reset = 1'b0;
        check(out_wr === 1'b0, "rst_out_wr", 128'(out_wr), 0);
        check(out_data === '0, "rst_out_data", 128'(out_data), 0);
        check(out_ctrl === '0, "rst_out_ctrl", 128'(out_ctrl), 0);
        check(pkt_cnt === '0, "rst_pkt_cnt", 128'(pkt_cnt), 0);
        check(in_rdy === '1, "rst_in_rdy", 128'(in_rdy), 128'hFF);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(sb.size() == 0, name, 128'(sb.size()), 0);
        sb.delete();
        idle_cycles(20);
    endtask

    initial begin
        // Single packet on queue 0, 4-cycle burst then the IDLE gap
        do_reset();
        load_pkt(0, 0, 4, 8'hFF);
        idle_cycles(12);
        expect_pkt(0, 0, 4, 8'hFF);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle_cycles(1);
            check(out_wr === 1'b1, "burst_out_wr", 128'(out_wr), 1);
        end
        idle_cycles(1);
        check(out_wr === 1'b0, "gap_out_wr", 128'(out_wr), 0);
        check(pkt_cnt[0 +: CNW] === exp_cnt(1), "pkt_cnt_q0_single",
              128'(pkt_cnt[0 +: CNW]), 128'(exp_cnt(1)));
        wait_drain("drain_single");

        // Eight queues, two packets each, all weights 1
        do_reset();
        for (int q = 0; q < NQ; q++) weights[q*WW +: WW] = 4'd1;
        load_pkt(0, 0, 3, 8'hFF);
        load_pkt(0, 1, 3, 8'hFF);
        idle_cycles(12);
        for (int q = 1; q < NQ; q++) begin
            load_pkt(q, 0, 3, 8'hFF);
            load_pkt(q, 1, 3, 8'hFF);
        end
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < NQ; q++) expect_pkt(q, p, 3, 8'hFF);
        out_rdy = 1'b1;
        wait_drain("drain_rr8");
        for (int q = 0; q < NQ; q++)
            check(pkt_cnt[q*CNW +: CNW] === exp_cnt(2), "pkt_cnt_rr8",
                  128'(pkt_cnt[q*CNW +: CNW]), 128'(exp_cnt(2)));

        // Weighted: q0=3, q1=1, others 0 (treated as 1)
        do_reset();
        weights = '0;
        weights[0 +: WW] = 4'd3;
        weights[WW +: WW] = 4'd1;
        for (int p = 0; p < 4; p++) load_pkt(0, p, 3, 8'h00);
        idle_cycles(12);
        for (int p = 0; p < 4; p++) load_pkt(1, p, 3, 8'h00);
        expect_pkt(0, 0, 3, 8'h00);
        expect_pkt(0, 1, 3, 8'h00);
        expect_pkt(0, 2, 3, 8'h00);
        expect_pkt(1, 0, 3, 8'h00);
        expect_pkt(0, 3, 3, 8'h00);
        expect_pkt(1, 1, 3, 8'h00);
        expect_pkt(1, 2, 3, 8'h00);
        expect_pkt(1, 3, 3, 8'h00);
        out_rdy = 1'b1;
        wait_drain("drain_wrr");
        check(pkt_cnt[0 +: CNW] === exp_cnt(4), "pkt_cnt_wrr_q0",
              128'(pkt_cnt[0 +: CNW]), 128'(exp_cnt(4)));
        check(pkt_cnt[CNW +: CNW] === exp_cnt(4), "pkt_cnt_wrr_q1",
              128'(pkt_cnt[CNW +: CNW]), 128'(exp_cnt(4)));

        // out_rdy toggling mid-packet
        do_reset();
        for (int q = 0; q < NQ; q++) weights[q*WW +: WW] = 4'd1;
        load_pkt(0, 0, 6, 8'h00);
        idle_cycles(12);
        expect_pkt(0, 0, 6, 8'h00);
        for (int i = 0; i < 16; i++) begin
            out_rdy = (i % 2 == 0);
            idle_cycles(1);
            if (!out_rdy) check(out_wr === 1'b0, "rdy_low_no_wr", 128'(out_wr), 0);
        end
        out_rdy = 1'b1;
        wait_drain("drain_toggle");

        // Queue 2 filled to nearly full
        do_reset();
        for (int i = 0; i < 30; i++) write_word(2, word_of(2, 0, i, 31, 8'h00));
        check(in_rdy === 8'hFF, "in_rdy_30_words", 128'(in_rdy), 128'hFF);
        write_word(2, word_of(2, 0, 30, 31, 8'h00));
        check(in_rdy === 8'hFB, "in_rdy_nearly_full", 128'(in_rdy), 128'hFB);
        expect_pkt(2, 0, 31, 8'h00);
        out_rdy = 1'b1;
        wait_drain("drain_fill");
        check(in_rdy === 8'hFF, "in_rdy_after_drain", 128'(in_rdy), 128'hFF);

        // Reset during XFER on queue 3 aborts the packet
        do_reset();
        load_pkt(3, 0, 5, 8'h00);
        idle_cycles(12);
        sb.push_back(word_of(3, 0, 0, 5, 8'h00));
        sb.push_back(word_of(3, 0, 1, 5, 8'h00));
        out_rdy = 1'b1;
        idle_cycles(2);
        reset = 1'b1;
        idle_cycles(1);
        check(out_wr === 1'b0, "midpkt_rst_out_wr", 128'(out_wr), 0);
        check(pkt_cnt === '0, "midpkt_rst_pkt_cnt", 128'(pkt_cnt), 0);
        check(sb.size() == 0, "midpkt_words_seen", 128'(sb.size()), 0);
        reset = 1'b0;
        check(in_rdy === 8'hFF, "midpkt_rst_in_rdy", 128'(in_rdy), 128'hFF);
        expect_pkt(0, 1, 4, 8'hFF);
        load_pkt(0, 1, 4, 8'hFF);
        wait_drain("drain_after_reset");
        check(pkt_cnt[0 +: CNW] === exp_cnt(1), "pkt_cnt_after_reset",
              128'(pkt_cnt[0 +: CNW]), 128'(exp_cnt(1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wrr_input_arbiter.md
# wrr_input_arbiter

Parametrised packet arbiter that merges `NUM_QUEUES` rx-queue streams into one datapath stream, serving whole packets in weighted round-robin order. It sits at the head of the user datapath, where the four-port round-robin input arbiter sits today. It adds:
- a generic queue count on flattened buses;
- a configurable per-queue input FIFO depth;
- a per-queue runtime weight giving consecutive packets per turn.

## Interface
Parameters:
- `DATA_WIDTH`, 64, datapath word width
- `CTRL_WIDTH`, `DATA_WIDTH/8`, ctrl width
- `NUM_QUEUES`, 8, number of input queues (≥2)
- `FIFO_DEPTH_BITS`, 5, log2 of per-queue FIFO depth
- `WEIGHT_WIDTH`, 4, width of each weight field
- `CNT_WIDTH`, 16, per-queue packet counter width

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `in_data` in `NUM_QUEUES*DATA_WIDTH`: queue i at slice [i*DATA_WIDTH +: DATA_WIDTH]
- `in_ctrl` in `NUM_QUEUES*CTRL_WIDTH`: per-queue ctrl, same slicing
- `in_wr` in `NUM_QUEUES`: per-queue write strobe
- `in_rdy` out `NUM_QUEUES`: per-queue ready = !nearly_full of that FIFO
- `weights` in `NUM_QUEUES*WEIGHT_WIDTH`: packets per turn, queue i; value 0 treated as 1
- `out_data` out `DATA_WIDTH`: registered output word
- `out_ctrl` out `CTRL_WIDTH`: registered output ctrl
- `out_wr` out 1: registered write strobe
- `out_rdy` in 1: downstream can accept a word this cycle
- `pkt_cnt` out `NUM_QUEUES*CNT_WIDTH`: packets forwarded per queue

## Operation
- One first-word-fall-through FIFO per queue, depth 2^`FIFO_DEPTH_BITS`, width `DATA_WIDTH+CTRL_WIDTH`.
  - Writing when `in_rdy`=0 is a protocol violation. The nearly-full margin of one word covers the registered upstream.
- Packet framing:
  - The first word popped after arbitration is the start of packet; its ctrl may be nonzero (module headers).
  - A word is end of packet (eop) when its ctrl≠0 and the previously popped word of that packet had ctrl==0.
- Registers:
  - `cur_queue` (`log2(NUM_QUEUES)` bits, wraps `NUM_QUEUES-1`→0).
  - `served` (`WEIGHT_WIDTH` bits).
  - `prev_ctrl_zero` flag.
- FSM IDLE:
  - If FIFO[`cur_queue`] is non-empty: go to XFER, clear `prev_ctrl_zero`.
  - Else advance `cur_queue` and clear `served`.
  - IDLE never pops.
- FSM XFER, on `out_rdy` && FIFO non-empty:
  - Pop the word; present it to the output registers with `out_wr_next`=1.
  - Update `prev_ctrl_zero` = (ctrl==0).
- FSM XFER, popped word is eop:
  - Increment `pkt_cnt[cur_queue]`, which wraps on overflow.
  - If `served+1` < effective weight: `served++` and keep `cur_queue`.
  - Otherwise clear `served` and advance `cur_queue`.
  - Go to IDLE in all cases.
- XFER with the FIFO empty mid-packet: stall in XFER with no pop and no `out_wr`; never switch queues mid-packet.
- The effective weight is sampled at each eop. A change to `weights` takes effect at the next eop.

## Timing
- Reset values:
  - `out_wr`=0, `out_data`=0, `out_ctrl`=0.
  - `pkt_cnt`=0, `cur_queue`=0, `served`=0, state IDLE.
  - All FIFOs flushed; `in_rdy`=all ones the cycle after `reset` deasserts.
- Reset asserted mid-packet aborts the packet. The partial packet is not completed, and its remaining words are discarded with the FIFO flush.
- Pop-to-output latency is 1 cycle: the word popped in cycle N appears with `out_wr`=1 in cycle N+1.
- `out_rdy` is sampled combinationally in the pop cycle. Downstream must accept the one in-flight word after deasserting `out_rdy`.
- Minimum inter-packet gap is 1 idle cycle (the IDLE state). Each empty queue skipped costs 1 cycle.
- Back-to-back words within a packet: one per cycle while `out_rdy`=1 and the FIFO is non-empty.
- A write and a pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.

## Configuration
- `IN_ARB_PKT_CNT_EN` defined: `pkt_cnt` counters are instantiated as described.
- Not defined: no counter logic; `pkt_cnt` is tied to 0.
- Arbitration is identical either way.

## Test plan
- Single packet on queue 0 (ctrl 0xFF, 0x00, 0x00, 0x01; `out_rdy`=1) → four words out, in order, on cycles N+1..N+4 after the first pop. Then IDLE, `pkt_cnt[0]`=1.
- Queues 0..7 each hold two 3-word packets, all weights 1 → output packet order 0,1,…,7,0,1,…,7.
- Weights q0=3, q1=1, each queue holding 4 packets → order 0,0,0,1,0,1,1,1.
- `out_rdy` toggled 1/0 every cycle mid-packet → no word lost or duplicated. At most one `out_wr` after each `out_rdy` falls.
- Queue 2 FIFO fed to nearly full → `in_rdy[2]`=0 while the other `in_rdy` bits stay 1.
- `reset` pulsed while in XFER on queue 3 → next cycle `out_wr`=0, `pkt_cnt`=0, `cur_queue`=0. A new packet on queue 0 then passes intact.
